sam_seq_ctrl: RTL and testbench

Sequential controller for the signed 32x32 shift-and-accumulate multiply. It takes one multiply request through a start/done handshake and runs one multiplier bit per clock. Each cycle it adds the shifted, sign-extended multiplicand into a 64-bit accumulator; the final (sign) bit subtracts instead of adding. It replaces the single-cycle combinational SAM wherever area matters more than latency, and presents the same operand and result naming.

---
 rtl/sam_seq_ctrl.sv | 103 ++++++++++
 tb/tb_sam_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sam_seq_ctrl.sv
// Sequential signed WIDTHxWIDTH shift-and-accumulate multiplier, one multiplier bit per clock.
// Latency: start accepted at edge N, done pulses with the new result after edge N+WIDTH.
// Backpressure: none; start is honoured only in IDLE and ignored (not queued) while RUN or DONE.
module sam_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        count;
  logic                 last;

  // The final multiplier bit is the sign bit and carries negative weight.
  assign last = (count == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: DONE lasts exactly one cycle, then back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator update for the current multiplier bit (add, subtract on the sign bit, or hold).
  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) begin
      acc_nxt = last ? (acc - mcand) : (acc + mcand);
    end
  end

  // Datapath: operand capture on accept, shift/accumulate in RUN, result latched on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
            mplier <= b;
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (last) begin
            result <= acc_nxt;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sam_seq_ctrl.sv
// Directed self-checking bench for sam_seq_ctrl at WIDTH=32.
// Each scenario task drives its own stimulus and compares against hand-computed products.
// Outputs are sampled 1ns after the rising edge; inputs change on the falling edge.
module tb_sam_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int checks;
  int failures;

  sam_seq_ctrl #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait until the controller is back in IDLE (bounded), leaving us just after a falling edge.
  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      if (!busy && !done) break;
      @(negedge clk);
    end
  endtask

  // Issue one operation and report the result seen on the done cycle and the edges taken.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib,
                       output logic [63:0] res, output int lat);
    wait_idle();
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    res = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [63:0] r;
    int          lat;
    int          ndone;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (result !== 64'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    // Leave a nonzero result so the abort visibly clears it.
    do_op(32'd90, 32'd70, r, lat);
    checks++; if (r !== 64'h0000_0000_0000_189C) begin failures++; $display("FAIL pre_reset_op got=%h exp=%h", r, 64'h189C); end
    wait_idle();
    a = 32'd50;
    b = 32'(-40);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrun_busy got=%0b exp=1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_rst_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL async_rst_done got=%0b exp=0", done); end
    checks++; if (result !== 64'h0) begin failures++; $display("FAIL async_rst_result got=%h exp=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL no_spurious_done got=%0d exp=0", ndone); end
  endtask

  task automatic test_products();
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic [63:0] te [5];
    logic [63:0] r;
    int          lat;
    ta[0] = 32'd50;      tb[0] = 32'(-40); te[0] = 64'hFFFF_FFFF_FFFF_F830;
    ta[1] = 32'd90;      tb[1] = 32'd70;   te[1] = 64'h0000_0000_0000_189C;
    ta[2] = 32'(-80);    tb[2] = 32'(-65); te[2] = 64'h0000_0000_0000_1450;
    ta[3] = 32'(-10);    tb[3] = 32'd325;  te[3] = 64'hFFFF_FFFF_FFFF_F34E;
    ta[4] = 32'(-999);   tb[4] = 32'd999;  te[4] = 64'hFFFF_FFFF_FFF0_C58F;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], r, lat);
      checks++; if (r !== te[i]) begin failures++; $display("FAIL product_%0d got=%h exp=%h", i, r, te[i]); end
      checks++; if (lat !== 32) begin failures++; $display("FAIL product_lat_%0d got=%0d exp=32", i, lat); end
    end
  endtask

  task automatic test_latency();
    int nbusy_bad;
    wait_idle();
    a = 32'd98765;
    b = 32'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nbusy_bad = 0;
    if (busy !== 1'b1 || done !== 1'b0) nbusy_bad++;
    for (int i = 1; i < 32; i++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1 || done !== 1'b0) nbusy_bad++;
    end
    checks++; if (nbusy_bad !== 0) begin failures++; $display("FAIL lat_busy_window bad_cycles=%0d exp=0", nbusy_bad); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL lat_done_edge got=%0b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL lat_busy_drop got=%0b exp=0", busy); end
    checks++; if (result !== 64'h0000_0000_0001_81CD) begin failures++; $display("FAIL lat_result got=%h exp=%h", result, 64'h181CD); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL lat_done_one_cycle got=%0b exp=0", done); end
  endtask

  task automatic test_extremes();
    logic [63:0] r;
    int          lat;
    do_op(32'h8000_0000, 32'h8000_0000, r, lat);
    checks++; if (r !== 64'h4000_0000_0000_0000) begin failures++; $display("FAIL ext_minmin got=%h exp=%h", r, 64'h4000_0000_0000_0000); end
    do_op(32'h7FFF_FFFF, 32'h8000_0000, r, lat);
    checks++; if (r !== 64'hC000_0000_8000_0000) begin failures++; $display("FAIL ext_maxmin got=%h exp=%h", r, 64'hC000_0000_8000_0000); end
    do_op(32'd98756, 32'd0, r, lat);
    checks++; if (r !== 64'h0) begin failures++; $display("FAIL ext_zero got=%h exp=0", r); end
    checks++; if (lat !== 32) begin failures++; $display("FAIL ext_zero_lat got=%0d exp=32", lat); end
  endtask

  task automatic test_start_while_busy();
    logic [63:0] r;
    int          lat;
    int          nextra;
    wait_idle();
    a = 32'd90;
    b = 32'd70;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    a = 32'(-500);
    b = 32'd2000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    r = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        r = result;
        break;
      end
    end
    checks++; if (r !== 64'd6300) begin failures++; $display("FAIL busy_start_ignored got=%h exp=%h", r, 64'd6300); end
    nextra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (busy || done) nextra++;
    end
    checks++; if (nextra !== 0) begin failures++; $display("FAIL busy_start_not_queued got=%0d exp=0", nextra); end
    do_op(32'(-500), 32'd2000, r, lat);
    checks++; if (r !== 64'hFFFF_FFFF_FFF0_BDC0) begin failures++; $display("FAIL reissue_result got=%h exp=%h", r, 64'hFFFF_FFFF_FFF0_BDC0); end
  endtask

  task automatic test_result_hold();
    logic [63:0] r;
    int          lat;
    int          nchg;
    do_op(32'(-80), 32'(-65), r, lat);
    checks++; if (r !== 64'h1450) begin failures++; $display("FAIL hold_setup got=%h exp=%h", r, 64'h1450); end
    wait_idle();
    a = 32'd50;
    b = 32'(-40);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nchg = 0;
    r = '0;
    for (int i = 0; i < 100; i++) begin
      // Scramble operands mid-run; only the accepted values may matter.
      a = 32'(i * 7 + 3);
      b = 32'(-i);
      @(posedge clk);
      #1;
      if (done) begin
        r = result;
        break;
      end
      if (result !== 64'h1450) nchg++;
    end
    checks++; if (nchg !== 0) begin failures++; $display("FAIL hold_during_run changed_cycles=%0d exp=0", nchg); end
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_F830) begin failures++; $display("FAIL hold_new_result got=%h exp=%h", r, 64'hFFFF_FFFF_FFFF_F830); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_products();
    test_latency();
    test_extremes();
    test_start_while_busy();
    test_result_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
